// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// global hold. The control bundle and operands from the decoder and register
// file are registered for the EX stage with one cycle of latency.
// A bubble clears every control bit, ALUOp and Valid_o, so it has no
// architectural side effect. Operands and register addresses still load
// during a bubble; EX ignores them.
// Optional feature macro: ID_EX_LOAD_USE_DETECT_EN. When it is defined, the
// stage detects a load-use hazard against the instruction in EX. It then
// stalls fetch/decode for one cycle and inserts a bubble. When it is not
// defined, the hazard term is tied low and Stall_o follows Hold only. The
// compiler must then place a nop after every load.
module id_ex_stage_register #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALUOP_WIDTH = 6,
  parameter int RADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Hold,
  input  logic                   Flush,
  input  logic                   RegDst_i,
  input  logic                   ALUSrc_i,
  input  logic                   MemtoReg_i,
  input  logic                   RegWrite_i,
  input  logic                   MemRead_i,
  input  logic                   MemWrite_i,
  input  logic                   BranchNE_i,
  input  logic                   BranchEQ_i,
  input  logic [ALUOP_WIDTH-1:0] ALUOp_i,
  input  logic [DATA_WIDTH-1:0]  ReadData1_i,
  input  logic [DATA_WIDTH-1:0]  ReadData2_i,
  input  logic [DATA_WIDTH-1:0]  Imm_i,
  input  logic [DATA_WIDTH-1:0]  PC4_i,
  input  logic [RADDR_WIDTH-1:0] Rs_i,
  input  logic [RADDR_WIDTH-1:0] Rt_i,
  input  logic [RADDR_WIDTH-1:0] Rd_i,
  output logic                   RegDst_o,
  output logic                   ALUSrc_o,
  output logic                   MemtoReg_o,
  output logic                   RegWrite_o,
  output logic                   MemRead_o,
  output logic                   MemWrite_o,
  output logic                   BranchNE_o,
  output logic                   BranchEQ_o,
  output logic [ALUOP_WIDTH-1:0] ALUOp_o,
  output logic [DATA_WIDTH-1:0]  ReadData1_o,
  output logic [DATA_WIDTH-1:0]  ReadData2_o,
  output logic [DATA_WIDTH-1:0]  Imm_o,
  output logic [DATA_WIDTH-1:0]  PC4_o,
  output logic [RADDR_WIDTH-1:0] Rs_o,
  output logic [RADDR_WIDTH-1:0] Rt_o,
  output logic [RADDR_WIDTH-1:0] Rd_o,
  output logic                   Valid_o,
  output logic                   Stall_o
);

  // Control bits that a bubble must clear, and operand/address fields that
  // always load.
  localparam int CTRL_WIDTH = 8 + ALUOP_WIDTH;
  localparam int DBUS_WIDTH = 4 * DATA_WIDTH + 3 * RADDR_WIDTH;

  logic [CTRL_WIDTH-1:0] ctrlIn_s;
  logic [CTRL_WIDTH-1:0] ctrlNext_s;
  logic [CTRL_WIDTH-1:0] ctrl_r;
  logic [DBUS_WIDTH-1:0] dataIn_s;
  logic [DBUS_WIDTH-1:0] dataNext_s;
  logic [DBUS_WIDTH-1:0] data_r;
  logic                  validNext_s;
  logic                  valid_r;
  logic                  loadUse_s;
  logic                  bubble_s;

  assign ctrlIn_s = {RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i,
                     MemRead_i, MemWrite_i, BranchNE_i, BranchEQ_i, ALUOp_i};
  assign dataIn_s = {ReadData1_i, ReadData2_i, Imm_i, PC4_i, Rs_i, Rt_i, Rd_i};

  // EX-facing outputs come straight from the stage registers.
  assign {RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o,
          MemRead_o, MemWrite_o, BranchNE_o, BranchEQ_o, ALUOp_o} = ctrl_r;
  assign {ReadData1_o, ReadData2_o, Imm_o, PC4_o, Rs_o, Rt_o, Rd_o} = data_r;
  assign Valid_o = valid_r;

`ifdef ID_EX_LOAD_USE_DETECT_EN
  logic usesRt_s;

  // Load in EX whose destination (Rt) is a source of the instruction in ID;
  // $0 never creates a dependency.
  always_comb begin
    usesRt_s  = RegDst_i | MemWrite_i | BranchEQ_i | BranchNE_i;
    loadUse_s = MemRead_o & valid_r & (Rt_o != {RADDR_WIDTH{1'b0}}) &
                ((Rt_o == Rs_i) | (usesRt_s & (Rt_o == Rt_i)));
  end
`else
  assign loadUse_s = 1'b0;
`endif

  assign bubble_s = Flush | loadUse_s;
  assign Stall_o  = Hold | loadUse_s;

  // Next-state selection: hold everything, insert a bubble, or load from ID.
  always_comb begin
    ctrlNext_s  = ctrl_r;
    dataNext_s  = data_r;
    validNext_s = valid_r;
    if (Hold) begin
      ctrlNext_s  = ctrl_r;
      dataNext_s  = data_r;
      validNext_s = valid_r;
    end else if (bubble_s) begin
      ctrlNext_s  = {CTRL_WIDTH{1'b0}};
      dataNext_s  = dataIn_s;
      validNext_s = 1'b0;
    end else begin
      ctrlNext_s  = ctrlIn_s;
      dataNext_s  = dataIn_s;
      validNext_s = 1'b1;
    end
  end

  // Stage registers; reset leaves a bubble and overrides hold, flush and stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_r  <= {CTRL_WIDTH{1'b0}};
      data_r  <= {DBUS_WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else begin
      ctrl_r  <= ctrlNext_s;
      data_r  <= dataNext_s;
      valid_r <= validNext_s;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Self-checking bench for id_ex_stage_register. Expected EX contents come
// from a small behavioural model and pass through a scoreboard queue. Stall_o
// is checked against the model before each edge.
module tb_id_ex_stage_register;

`ifdef ID_EX_LOAD_USE_DETECT_EN
  localparam bit LU_EN = 1'b1;
`else
  localparam bit LU_EN = 1'b0;
`endif

  typedef struct packed {
    logic        regDst;
    logic        aluSrc;
    logic        memtoReg;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        branchNE;
    logic        branchEQ;
    logic [5:0]  aluOp;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
  } bundle_t;

  logic    clk;
  logic    rstB;
  logic    holdB;
  logic    flushB;
  bundle_t inB;

  logic        RegDst_o, ALUSrc_o, MemtoReg_o, RegWrite_o;
  logic        MemRead_o, MemWrite_o, BranchNE_o, BranchEQ_o;
  logic [5:0]  ALUOp_o;
  logic [31:0] ReadData1_o, ReadData2_o, Imm_o, PC4_o;
  logic [4:0]  Rs_o, Rt_o, Rd_o;
  logic        Valid_o, Stall_o;

  bundle_t mdl;
  bundle_t q[$];
  int      checks;
  int      fails;

  id_ex_stage_register dut (
    .clk(clk), .reset(rstB), .Hold(holdB), .Flush(flushB),
    .RegDst_i(inB.regDst), .ALUSrc_i(inB.aluSrc), .MemtoReg_i(inB.memtoReg),
    .RegWrite_i(inB.regWrite), .MemRead_i(inB.memRead), .MemWrite_i(inB.memWrite),
    .BranchNE_i(inB.branchNE), .BranchEQ_i(inB.branchEQ), .ALUOp_i(inB.aluOp),
    .ReadData1_i(inB.rd1), .ReadData2_i(inB.rd2), .Imm_i(inB.imm), .PC4_i(inB.pc4),
    .Rs_i(inB.rs), .Rt_i(inB.rt), .Rd_i(inB.rd),
    .RegDst_o(RegDst_o), .ALUSrc_o(ALUSrc_o), .MemtoReg_o(MemtoReg_o),
    .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .BranchNE_o(BranchNE_o), .BranchEQ_o(BranchEQ_o), .ALUOp_o(ALUOp_o),
    .ReadData1_o(ReadData1_o), .ReadData2_o(ReadData2_o), .Imm_o(Imm_o), .PC4_o(PC4_o),
    .Rs_o(Rs_o), .Rt_o(Rt_o), .Rd_o(Rd_o), .Valid_o(Valid_o), .Stall_o(Stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction builders ----------------
  function automatic bundle_t blank();
    bundle_t b;
    b     = '0;
    b.rd2 = $urandom;
    b.imm = $urandom;
    b.pc4 = $urandom;
    return b;
  endfunction

  function automatic bundle_t rtype(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [31:0] a);
    bundle_t b;
    b = blank();
    b.regDst = 1'b1; b.regWrite = 1'b1; b.aluOp = 6'h00;
    b.rs = rs; b.rt = rt; b.rd = rd; b.rd1 = a;
    return b;
  endfunction

  function automatic bundle_t lw(input logic [4:0] rs, input logic [4:0] rt);
    bundle_t b;
    b = blank();
    b.aluSrc = 1'b1; b.memtoReg = 1'b1; b.regWrite = 1'b1; b.memRead = 1'b1;
    b.aluOp = 6'h23; b.rs = rs; b.rt = rt; b.rd1 = $urandom;
    return b;
  endfunction

  function automatic bundle_t sw(input logic [4:0] rs, input logic [4:0] rt);
    bundle_t b;
    b = blank();
    b.aluSrc = 1'b1; b.memWrite = 1'b1; b.aluOp = 6'h2b;
    b.rs = rs; b.rt = rt; b.rd1 = $urandom;
    return b;
  endfunction

  function automatic bundle_t ori(input logic [4:0] rs, input logic [4:0] rt);
    bundle_t b;
    b = blank();
    b.aluSrc = 1'b1; b.regWrite = 1'b1; b.aluOp = 6'h0d;
    b.rs = rs; b.rt = rt; b.rd1 = $urandom;
    return b;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic lu(input bundle_t cur, input bundle_t id);
    logic usesRt;
    usesRt = id.regDst | id.memWrite | id.branchEQ | id.branchNE;
    return LU_EN & cur.memRead & cur.valid & (cur.rt != 5'd0) &
           ((cur.rt == id.rs) | (usesRt & (cur.rt == id.rt)));
  endfunction

  function automatic bundle_t nextModel(input bundle_t cur, input bundle_t id,
                                        input logic r, input logic h, input logic f);
    bundle_t n;
    if (!r) return '0;
    if (h) return cur;
    n = id;
    n.valid = 1'b1;
    if (f | lu(cur, id)) begin
      n.regDst = 1'b0; n.aluSrc = 1'b0; n.memtoReg = 1'b0; n.regWrite = 1'b0;
      n.memRead = 1'b0; n.memWrite = 1'b0; n.branchNE = 1'b0; n.branchEQ = 1'b0;
      n.aluOp = 6'h00; n.valid = 1'b0;
    end
    return n;
  endfunction

  function automatic bundle_t observe();
    bundle_t b;
    b.regDst = RegDst_o; b.aluSrc = ALUSrc_o; b.memtoReg = MemtoReg_o;
    b.regWrite = RegWrite_o; b.memRead = MemRead_o; b.memWrite = MemWrite_o;
    b.branchNE = BranchNE_o; b.branchEQ = BranchEQ_o; b.aluOp = ALUOp_o;
    b.rd1 = ReadData1_o; b.rd2 = ReadData2_o; b.imm = Imm_o; b.pc4 = PC4_o;
    b.rs = Rs_o; b.rt = Rt_o; b.rd = Rd_o; b.valid = Valid_o;
    return b;
  endfunction

  // Apply ID inputs and control, then settle at the falling edge.
  task automatic drive(input bundle_t b, input logic r, input logic h, input logic f);
    inB = b; rstB = r; holdB = h; flushB = f;
    @(negedge clk);
  endtask

  // Predict the EX contents for this edge, queue them, then take the edge.
  task automatic tick();
    bundle_t n;
    n = nextModel(mdl, inB, rstB, holdB, flushB);
    mdl = n;
    q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bundle_t e;
    logic hs[3];
    hs[0] = 1'b1; hs[1] = 1'b1; hs[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive('1, 1'b0, hs[k], 1'b1);
      if (k > 0) begin
        checks++;
        if (Stall_o !== hs[k]) begin
          fails++; $display("FAIL reset_stall: got %b, want %b", Stall_o, hs[k]);
        end
      end
      tick();
      e = q.pop_front();
      checks++;
      if (observe() !== e || Valid_o !== 1'b0 || RegWrite_o !== 1'b0) begin
        fails++; $display("FAIL reset_out: got %h, want %h", observe(), e);
      end
    end
  endtask

  task automatic test_rtype();
    bundle_t e;
    drive(rtype(5'd1, 5'd2, 5'd3, 32'h5), 1'b1, 1'b0, 1'b0);
    checks++;
    if (Stall_o !== 1'b0) begin
      fails++; $display("FAIL rtype_stall: got %b, want 0", Stall_o);
    end
    tick();
    e = q.pop_front();
    checks++;
    if (RegWrite_o !== 1'b1 || ReadData1_o !== 32'h5 || Valid_o !== 1'b1 || observe() !== e) begin
      fails++; $display("FAIL rtype_out: got %h, want %h", observe(), e);
    end
  endtask

  task automatic test_back_to_back();
    bundle_t e;
    bundle_t b;
    for (int k = 0; k < 6; k++) begin
      b = (k % 2 == 0) ? rtype(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'd4, $urandom)
                       : ori(5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
      drive(b, 1'b1, 1'b0, 1'b0);
      tick();
      e = q.pop_front();
      checks++;
      if (observe() !== e || Valid_o !== 1'b1) begin
        fails++; $display("FAIL b2b_out[%0d]: got %h, want %h", k, observe(), e);
      end
    end
  endtask

  // Runs a program; an instruction predicted to stall is presented again.
  task automatic test_load_use();
    bundle_t prog[$];
    bundle_t e;
    logic    st;
    int      tries;
    prog = '{lw(5'd1, 5'd8), rtype(5'd8, 5'd2, 5'd9, 32'h11),
             lw(5'd1, 5'd9), sw(5'd4, 5'd9),
             lw(5'd1, 5'd10), ori(5'd2, 5'd10),
             lw(5'd1, 5'd11), lw(5'd11, 5'd12), rtype(5'd3, 5'd12, 5'd13, 32'h22)};
    foreach (prog[i]) begin
      tries = 0;
      do begin
        drive(prog[i], 1'b1, 1'b0, 1'b0);
        st = lu(mdl, prog[i]);
        checks++;
        if (Stall_o !== st) begin
          fails++; $display("FAIL lu_stall[%0d]: got %b, want %b", i, Stall_o, st);
        end
        tick();
        e = q.pop_front();
        checks++;
        if (observe() !== e) begin
          fails++; $display("FAIL lu_out[%0d]: got %h, want %h", i, observe(), e);
        end
        tries++;
      end while (st && tries < 3);
      if (tries > 2) begin
        checks++; fails++;
        $display("FAIL lu_stall_len[%0d]: got %0d cycles, want <=2", i, tries);
      end
    end
    // Spot checks on the canonical LW Rt=8 / ADD Rs=8 pair.
    drive(lw(5'd1, 5'd8), 1'b1, 1'b0, 1'b0);
    tick(); e = q.pop_front();
    drive(rtype(5'd8, 5'd2, 5'd9, 32'h33), 1'b1, 1'b0, 1'b0);
    checks++;
    if (Stall_o !== LU_EN) begin
      fails++; $display("FAIL lw_add_stall: got %b, want %b", Stall_o, LU_EN);
    end
    tick(); e = q.pop_front();
    checks++;
    if (Valid_o !== !LU_EN || RegWrite_o !== !LU_EN || observe() !== e) begin
      fails++; $display("FAIL lw_add_bubble: got %h, want %h", observe(), e);
    end
    if (LU_EN) begin
      drive(rtype(5'd8, 5'd2, 5'd9, 32'h33), 1'b1, 1'b0, 1'b0);
      checks++;
      if (Stall_o !== 1'b0) begin
        fails++; $display("FAIL lw_add_restall: got %b, want 0", Stall_o);
      end
      tick(); e = q.pop_front();
      checks++;
      if (Valid_o !== 1'b1 || ReadData1_o !== 32'h33 || observe() !== e) begin
        fails++; $display("FAIL lw_add_enter: got %h, want %h", observe(), e);
      end
    end
  endtask

  task automatic test_zero_reg();
    bundle_t e;
    drive(lw(5'd1, 5'd0), 1'b1, 1'b0, 1'b0);
    tick(); e = q.pop_front();
    drive(rtype(5'd0, 5'd0, 5'd6, 32'h44), 1'b1, 1'b0, 1'b0);
    checks++;
    if (Stall_o !== 1'b0) begin
      fails++; $display("FAIL zero_stall: got %b, want 0", Stall_o);
    end
    tick(); e = q.pop_front();
    checks++;
    if (Valid_o !== 1'b1 || observe() !== e) begin
      fails++; $display("FAIL zero_out: got %h, want %h", observe(), e);
    end
  endtask

  task automatic test_hold();
    bundle_t e;
    bundle_t snap;
    drive(lw(5'd1, 5'd8), 1'b1, 1'b0, 1'b0);
    tick(); snap = q.pop_front();
    for (int k = 0; k < 3; k++) begin
      drive(rtype(5'd8, 5'($urandom), 5'($urandom), $urandom), 1'b1, 1'b1, 1'b1);
      checks++;
      if (Stall_o !== 1'b1) begin
        fails++; $display("FAIL hold_stall[%0d]: got %b, want 1", k, Stall_o);
      end
      tick(); e = q.pop_front();
      checks++;
      if (observe() !== snap || observe() !== e) begin
        fails++; $display("FAIL hold_out[%0d]: got %h, want %h", k, observe(), snap);
      end
    end
    // Hold drops with the dependent ADD still in ID.
    drive(rtype(5'd8, 5'd2, 5'd9, 32'h55), 1'b1, 1'b0, 1'b0);
    checks++;
    if (Stall_o !== LU_EN) begin
      fails++; $display("FAIL hold_release_stall: got %b, want %b", Stall_o, LU_EN);
    end
    tick(); e = q.pop_front();
    checks++;
    if (observe() !== e) begin
      fails++; $display("FAIL hold_release_out: got %h, want %h", observe(), e);
    end
  endtask

  task automatic test_flush();
    bundle_t e;
    drive(ori(5'd3, 5'd4), 1'b1, 1'b0, 1'b1);
    tick(); e = q.pop_front();
    checks++;
    if (ALUOp_o !== 6'h00 || Valid_o !== 1'b0 || observe() !== e) begin
      fails++; $display("FAIL flush_ori: got %h, want %h", observe(), e);
    end
    // Flush coinciding with a load-use hazard: single bubble, no extra stall.
    drive(lw(5'd1, 5'd8), 1'b1, 1'b0, 1'b0);
    tick(); e = q.pop_front();
    drive(rtype(5'd8, 5'd2, 5'd9, 32'h66), 1'b1, 1'b0, 1'b1);
    tick(); e = q.pop_front();
    checks++;
    if (Valid_o !== 1'b0 || RegWrite_o !== 1'b0 || MemRead_o !== 1'b0 || observe() !== e) begin
      fails++; $display("FAIL flush_lu_bubble: got %h, want %h", observe(), e);
    end
    drive(rtype(5'd1, 5'd2, 5'd3, 32'h77), 1'b1, 1'b0, 1'b0);
    checks++;
    if (Stall_o !== 1'b0) begin
      fails++; $display("FAIL flush_lu_nostall: got %b, want 0", Stall_o);
    end
    tick(); e = q.pop_front();
    checks++;
    if (Valid_o !== 1'b1 || observe() !== e) begin
      fails++; $display("FAIL flush_after: got %h, want %h", observe(), e);
    end
  endtask

  task automatic test_reset_mid();
    bundle_t e;
    drive(lw(5'd1, 5'd8), 1'b1, 1'b0, 1'b0);
    tick(); e = q.pop_front();
    drive(rtype(5'd8, 5'd2, 5'd9, 32'h88), 1'b0, 1'b1, 1'b0);
    tick(); e = q.pop_front();
    checks++;
    if (observe() !== e || Valid_o !== 1'b0 || MemRead_o !== 1'b0) begin
      fails++; $display("FAIL reset_mid_out: got %h, want %h", observe(), e);
    end
    drive(rtype(5'd8, 5'd2, 5'd9, 32'h88), 1'b1, 1'b0, 1'b0);
    checks++;
    if (Stall_o !== 1'b0) begin
      fails++; $display("FAIL reset_mid_stall: got %b, want 0", Stall_o);
    end
    tick(); e = q.pop_front();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    mdl    = '0;
    inB    = '0;
    rstB   = 1'b0;
    holdB  = 1'b0;
    flushB = 1'b0;
    test_reset();
    test_rtype();
    test_back_to_back();
    test_load_use();
    test_zero_reg();
    test_hold();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
